multi_channel_deglitch: RTL and testbench

//  N-channel bipolar deglitch filter for asynchronous board inputs (limit switches, encoder

---
 rtl/deglitch_pkg.sv | 14 +
 rtl/deglitch_channel.sv | 74 +++++++
 rtl/multi_channel_deglitch.sv | 62 ++++++
 tb/tb_multi_channel_deglitch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deglitch_pkg.sv
// Shared types and defaults for the multi-channel deglitch filter.
package deglitch_pkg;

   localparam int DEFAULT_COUNTER_WIDTH = 16;

   // Registered per-channel status as seen at the top-level outputs.
   typedef struct packed {
      logic out;
      logic rise;
      logic fall;
      logic glitch;
   } chan_status_t;

endpackage

// File: rtl/deglitch_channel.sv
// One deglitch channel: input synchroniser, stability counter, filtered level
// and the rise/fall/glitch event pulses derived from it.
module deglitch_channel
   import deglitch_pkg::*;
#(
   parameter int COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
   parameter int SYNC_STAGES    = 2,
   parameter bit DEFAULT_OUTPUT = 1'b0,
   parameter bit BIPOLAR        = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic [COUNTER_WIDTH-1:0] delay,
   input  logic                     raw,
   output chan_status_t             status,
   output logic                     glitch_set
);

   logic [SYNC_STAGES-1:0]   sync_p0;
   logic                     s;
   logic [COUNTER_WIDTH-1:0] cnt_p1;
   logic [COUNTER_WIDTH-1:0] cnt_nxt;
   chan_status_t             st_p1;
   chan_status_t             st_nxt;

   // Counter increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
      return (&v) ? v : v + COUNTER_WIDTH'(1);
   endfunction

   assign s = sync_p0[SYNC_STAGES-1];

   // Next-state for counter, filtered level and event pulses; pulses only on enabled ticks.
   always_comb begin
      cnt_nxt       = cnt_p1;
      st_nxt.out    = st_p1.out;
      st_nxt.rise   = 1'b0;
      st_nxt.fall   = 1'b0;
      st_nxt.glitch = 1'b0;
      if (clk_en) begin
         if (s == st_p1.out) begin
            // Input back at the current level: any partial count was a rejected excursion.
            cnt_nxt       = '0;
            st_nxt.glitch = (cnt_p1 != '0);
         end else if (((BIPOLAR == 1'b0) && (s == DEFAULT_OUTPUT)) || (cnt_p1 >= delay)) begin
            // Stable long enough, or a return to idle level in unipolar mode.
            st_nxt.out  = s;
            st_nxt.rise = s;
            st_nxt.fall = ~s;
            cnt_nxt     = '0;
         end else begin
            cnt_nxt = sat_inc(cnt_p1);
         end
      end
   end

   assign glitch_set = st_nxt.glitch;
   assign status     = st_p1;

   // Stage p0: synchroniser shifts every clock; stage p1: counter and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= {SYNC_STAGES{DEFAULT_OUTPUT}};
         cnt_p1  <= '0;
         st_p1   <= '{out: DEFAULT_OUTPUT, rise: 1'b0, fall: 1'b0, glitch: 1'b0};
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
         cnt_p1  <= cnt_nxt;
         st_p1   <= st_nxt;
      end
   end

endmodule

// File: rtl/multi_channel_deglitch.sv
// N-channel deglitch filter: one deglitch_channel per input, a shared delay
// threshold and per-channel sticky glitch flags.
module multi_channel_deglitch
   import deglitch_pkg::*;
#(
   parameter int                  CHANNELS       = 8,
   parameter int                  COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
   parameter int                  SYNC_STAGES    = 2,
   parameter logic [CHANNELS-1:0] DEFAULT_OUTPUT = '0,
   parameter bit                  BIPOLAR        = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic [COUNTER_WIDTH-1:0] delay,
   input  logic [CHANNELS-1:0]      in,
   output logic [CHANNELS-1:0]      out,
   output logic [CHANNELS-1:0]      rise,
   output logic [CHANNELS-1:0]      fall,
   output logic [CHANNELS-1:0]      glitch,
   output logic [CHANNELS-1:0]      glitch_sticky,
   input  logic [CHANNELS-1:0]      glitch_clear
);

   chan_status_t        status [CHANNELS];
   logic [CHANNELS-1:0] glitch_set;
   logic [CHANNELS-1:0] sticky_p1;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      deglitch_channel #(
         .COUNTER_WIDTH  (COUNTER_WIDTH),
         .SYNC_STAGES    (SYNC_STAGES),
         .DEFAULT_OUTPUT (DEFAULT_OUTPUT[i]),
         .BIPOLAR        (BIPOLAR)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .clk_en     (clk_en),
         .delay      (delay),
         .raw        (in[i]),
         .status     (status[i]),
         .glitch_set (glitch_set[i])
      );

      assign out[i]    = status[i].out;
      assign rise[i]   = status[i].rise;
      assign fall[i]   = status[i].fall;
      assign glitch[i] = status[i].glitch;
   end

   // Sticky glitch flags: set alongside the glitch pulse, and a set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_p1 <= '0;
      end else begin
         sticky_p1 <= (sticky_p1 & ~glitch_clear) | glitch_set;
      end
   end

   assign glitch_sticky = sticky_p1;

endmodule

// File: tb/tb_multi_channel_deglitch.sv
// Bench for multi_channel_deglitch: a bipolar instance with mixed idle levels
// and a unipolar instance, checked through a cycle-tagged scoreboard.
module tb_multi_channel_deglitch;

   localparam int          CW  = 8;
   localparam int          SS  = 2;
   localparam logic [7:0]  DEF = 8'h81;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_en;
   logic [CW-1:0] delay, delay_u;
   logic [7:0]    in_m, in_u, clr_m, clr_u;
   logic [7:0]    out_m, rise_m, fall_m, gl_m, st_m;
   logic [7:0]    out_u, rise_u, fall_u, gl_u, st_u;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      bit         u;
      logic [7:0] out, rise, fall, glitch, sticky;
      string      name;
   } exp_t;

   typedef struct {
      string name;
      int    ch;
      int    dly;
      int    len;
      bit    sw;
      int    off;
   } vec_t;

   exp_t sb[$];

   multi_channel_deglitch #(
      .CHANNELS(8), .COUNTER_WIDTH(CW), .SYNC_STAGES(SS),
      .DEFAULT_OUTPUT(DEF), .BIPOLAR(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .delay(delay), .in(in_m),
      .out(out_m), .rise(rise_m), .fall(fall_m), .glitch(gl_m),
      .glitch_sticky(st_m), .glitch_clear(clr_m)
   );

   multi_channel_deglitch #(
      .CHANNELS(8), .COUNTER_WIDTH(CW), .SYNC_STAGES(SS),
      .DEFAULT_OUTPUT(8'h00), .BIPOLAR(1'b0)
   ) dut_u (
      .clk(clk), .reset(reset), .clk_en(clk_en), .delay(delay_u), .in(in_u),
      .out(out_u), .rise(rise_u), .fall(fall_u), .glitch(gl_u),
      .glitch_sticky(st_u), .glitch_clear(clr_u)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Compare every scoreboard entry due at this cycle against the DUT outputs.
   always @(negedge clk) begin
      exp_t        e;
      logic [39:0] act, want;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e    = sb.pop_front();
         act  = e.u ? {out_u, rise_u, fall_u, gl_u, st_u} : {out_m, rise_m, fall_m, gl_m, st_m};
         want = {e.out, e.rise, e.fall, e.glitch, e.sticky};
         n_checks++;
         if (e.cyc != cyc || act !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d (due %0d): got out=%h rise=%h fall=%h glitch=%h sticky=%h, want out=%h rise=%h fall=%h glitch=%h sticky=%h",
                     e.name, cyc, e.cyc, act[39:32], act[31:24], act[23:16], act[15:8], act[7:0],
                     e.out, e.rise, e.fall, e.glitch, e.sticky);
         end
      end
   end

   function automatic void pm(int c, bit u, string nm, logic [7:0] o, r, f, g, s);
      exp_t e;
      e.cyc = c; e.u = u; e.name = nm;
      e.out = o; e.rise = r; e.fall = f; e.glitch = g; e.sticky = s;
      sb.push_back(e);
   endfunction

   task automatic step(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_to(int c);
      while (cyc < c) step();
   endtask

   task automatic gated_to(int c);
      while (cyc < c) begin
         clk_en = ((cyc + 1) % 4 == 0);
         step();
      end
   endtask

   task automatic drain(int budget);
      int k = 0;
      while (sb.size() > 0 && k < budget) begin
         step();
         k++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected entries never came due, want 0", sb.size());
         sb.delete();
      end
   endtask

   // Third enabled tick (posedge with cycle%4==0) after the synchroniser has the new level.
   function automatic int third_tick(int p);
      int k = 0;
      int t = p + SS;
      while (k < 3) begin
         t++;
         if (t % 4 == 0) k++;
      end
      return t;
   endfunction

   initial begin
      vec_t       vt[6];
      int         p, q, t;
      logic [7:0] eo, es, m, o1, rm, fm;

      // vector table: offsets are cycles from the input edge to the expected event
      vt[0] = '{name: "d3_hold",   ch: 2, dly: 3, len: 10, sw: 1'b1, off: SS + 4};
      vt[1] = '{name: "d5_pulse3", ch: 2, dly: 5, len: 3,  sw: 1'b0, off: SS + 3 + 1};
      vt[2] = '{name: "d0_pass",   ch: 4, dly: 0, len: 4,  sw: 1'b1, off: SS + 1};
      vt[3] = '{name: "d2_len2",   ch: 5, dly: 2, len: 2,  sw: 1'b0, off: SS + 2 + 1};
      vt[4] = '{name: "d2_len3",   ch: 6, dly: 2, len: 3,  sw: 1'b1, off: SS + 3};
      vt[5] = '{name: "ch0_low",   ch: 0, dly: 1, len: 5,  sw: 1'b1, off: SS + 2};

      eo = DEF;
      es = 8'h00;

      // reset held three clocks while inputs toggle
      reset = 1'b1; clk_en = 1'b1; delay = CW'(3); delay_u = CW'(4);
      in_m = 8'h00; in_u = 8'hFF; clr_m = 8'h00; clr_u = 8'h00;
      step();
      pm(2, 1'b0, "reset_c2", DEF, 0, 0, 0, 0);
      pm(3, 1'b0, "reset_c3", DEF, 0, 0, 0, 0);
      pm(3, 1'b1, "reset_u_c3", 8'h00, 0, 0, 0, 0);
      in_m = ~in_m; in_u = ~in_u;
      step();
      in_m = ~in_m; in_u = ~in_u;
      step();
      reset = 1'b0; in_m = DEF; in_u = 8'h00;
      for (int c = 4; c <= 6; c++) pm(c, 1'b0, "post_reset", DEF, 0, 0, 0, 0);
      pm(6, 1'b1, "post_reset_u", 8'h00, 0, 0, 0, 0);
      drain(20);

      // table-driven excursions on the bipolar instance
      for (int i = 0; i < 6; i++) begin
         delay = CW'(vt[i].dly);
         step();
         p = cyc;
         m = 8'h01 << vt[i].ch;
         in_m = in_m ^ m;
         if (vt[i].sw) begin
            o1 = eo ^ m;
            rm = (DEF & m) != 0 ? 8'h00 : m;
            fm = (DEF & m) != 0 ? m : 8'h00;
            pm(p + vt[i].off - 1, 1'b0, {vt[i].name, "_pre"},  eo, 0, 0, 0, es);
            pm(p + vt[i].off,     1'b0, {vt[i].name, "_sw"},   o1, rm, fm, 0, es);
            pm(p + vt[i].off + 1, 1'b0, {vt[i].name, "_post"}, o1, 0, 0, 0, es);
            pm(p + vt[i].len + vt[i].off - 1, 1'b0, {vt[i].name, "_back_pre"},  o1, 0, 0, 0, es);
            pm(p + vt[i].len + vt[i].off,     1'b0, {vt[i].name, "_back"},      eo, fm, rm, 0, es);
            pm(p + vt[i].len + vt[i].off + 1, 1'b0, {vt[i].name, "_back_post"}, eo, 0, 0, 0, es);
            run_to(p + vt[i].len);
            in_m = in_m ^ m;
            drain(60);
         end else begin
            pm(p + vt[i].off - 1, 1'b0, {vt[i].name, "_pre"},    eo, 0, 0, 0, es);
            pm(p + vt[i].off,     1'b0, {vt[i].name, "_glitch"}, eo, 0, 0, m, es | m);
            pm(p + vt[i].off + 1, 1'b0, {vt[i].name, "_sticky"}, eo, 0, 0, 0, es | m);
            run_to(p + vt[i].len);
            in_m = in_m ^ m;
            drain(60);
            step(3);
            pm(cyc + 1, 1'b0, {vt[i].name, "_held"}, eo, 0, 0, 0, es | m);
            step();
            clr_m = m;
            pm(cyc + 1, 1'b0, {vt[i].name, "_clear"}, eo, 0, 0, 0, es);
            step();
            clr_m = 8'h00;
            drain(10);
         end
      end

      // clear coinciding with a glitch: the set must win
      delay = CW'(5);
      step();
      p = cyc;
      m = 8'h08;
      in_m = in_m ^ m;
      pm(p + SS + 3, 1'b0, "setwins_glitch", eo, 0, 0, m, m);
      pm(p + SS + 4, 1'b0, "setwins_hold",   eo, 0, 0, 0, m);
      run_to(p + 2);
      in_m = in_m ^ m;
      run_to(p + SS + 2);
      clr_m = m;
      step();
      clr_m = 8'h00;
      drain(20);
      clr_m = m;
      pm(cyc + 1, 1'b0, "setwins_clear", eo, 0, 0, 0, 8'h00);
      step();
      clr_m = 8'h00;
      drain(10);

      // lowering delay below a running count switches on the next enabled tick
      delay = CW'(10);
      step();
      p = cyc;
      in_m = in_m ^ m;
      pm(p + 5, 1'b0, "lower_pre",  eo, 0, 0, 0, 0);
      pm(p + 6, 1'b0, "lower_sw",   eo | m, m, 0, 0, 0);
      pm(p + 7, 1'b0, "lower_post", eo | m, 0, 0, 0, 0);
      run_to(p + 5);
      delay = CW'(2);
      drain(20);
      q = cyc;
      in_m = in_m ^ m;
      pm(q + SS + 2, 1'b0, "lower_back_pre", eo | m, 0, 0, 0, 0);
      pm(q + SS + 3, 1'b0, "lower_back",     eo, 0, m, 0, 0);
      drain(20);

      // reset in the middle of a count discards it
      delay = CW'(5);
      step();
      p = cyc;
      m = 8'h04;
      in_m = in_m ^ m;
      run_to(p + 4);
      reset = 1'b1;
      pm(p + 5, 1'b0, "midreset_hold", eo, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      pm(p + 5 + SS + 5, 1'b0, "midreset_pre", eo, 0, 0, 0, 0);
      pm(p + 5 + SS + 6, 1'b0, "midreset_sw",  eo | m, m, 0, 0, 0);
      drain(30);
      q = cyc;
      in_m = in_m ^ m;
      pm(q + SS + 6, 1'b0, "midreset_back", eo, 0, m, 0, 0);
      drain(30);

      // clk_en every fourth clock, delay 2: switch on the third enabled tick
      delay = CW'(2);
      step();
      p = cyc;
      m = 8'h40;
      in_m = in_m ^ m;
      t = third_tick(p);
      pm(t - 1, 1'b0, "gated_pre",  eo, 0, 0, 0, 0);
      pm(t,     1'b0, "gated_sw",   eo | m, m, 0, 0, 0);
      pm(t + 1, 1'b0, "gated_post", eo | m, 0, 0, 0, 0);
      gated_to(t + 2);
      drain(4);
      q = cyc;
      in_m = in_m ^ m;
      t = third_tick(q);
      pm(t - 1, 1'b0, "gated_back_pre", eo | m, 0, 0, 0, 0);
      pm(t,     1'b0, "gated_back",     eo, 0, m, 0, 0);
      gated_to(t + 2);
      clk_en = 1'b1;
      drain(4);

      // largest delay: counter must reach all-ones without wrapping
      delay = {CW{1'b1}};
      step();
      p = cyc;
      m = 8'h20;
      in_m = in_m ^ m;
      pm(p + SS + 255, 1'b0, "maxdly_pre", eo, 0, 0, 0, 0);
      pm(p + SS + 256, 1'b0, "maxdly_sw",  eo | m, m, 0, 0, 0);
      drain(300);
      delay = CW'(0);
      q = cyc;
      in_m = in_m ^ m;
      pm(q + SS + 1, 1'b0, "maxdly_back", eo, 0, m, 0, 0);
      drain(10);

      // unipolar instance: filtered rise, unfiltered release to idle level
      step();
      p = cyc;
      m = 8'h02;
      in_u = in_u ^ m;
      pm(p + SS + 4, 1'b1, "uni_rise_pre", 8'h00, 0, 0, 0, 0);
      pm(p + SS + 5, 1'b1, "uni_rise",     m, m, 0, 0, 0);
      drain(20);
      step();
      q = cyc;
      in_u = in_u ^ m;
      pm(q + SS,     1'b1, "uni_rel_pre",  m, 0, 0, 0, 0);
      pm(q + SS + 1, 1'b1, "uni_release",  8'h00, 0, m, 0, 0);
      pm(q + SS + 2, 1'b1, "uni_rel_post", 8'h00, 0, 0, 0, 0);
      drain(20);

      // short excursion away from idle on the unipolar instance is still rejected
      step();
      p = cyc;
      in_u = in_u ^ m;
      pm(p + SS + 3, 1'b1, "uni_glitch", 8'h00, 0, 0, m, m);
      run_to(p + 2);
      in_u = in_u ^ m;
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
